// File: rtl/neokeon_pkg.sv
// Shared Noekeon round types: 32-bit words, 4-word state, rotation amounts
// and helpers to split/join a 128-bit block into words a0..a3 (a0 = MSW).
package neokeon_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] block_t;

    typedef struct packed {
        word_t a0;
        word_t a1;
        word_t a2;
        word_t a3;
    } state_t;

    localparam int unsigned ROT_THETA = 8;
    localparam int unsigned PI_ROT_A1 = 1;
    localparam int unsigned PI_ROT_A2 = 5;
    localparam int unsigned PI_ROT_A3 = 2;

    function automatic state_t split_state(input block_t b);
        state_t s;
        s.a0 = b[127:96];
        s.a1 = b[95:64];
        s.a2 = b[63:32];
        s.a3 = b[31:0];
        return s;
    endfunction

    function automatic block_t join_state(input state_t s);
        return {s.a0, s.a1, s.a2, s.a3};
    endfunction

    // Amounts are always in 1..31, so the complementary shift never reaches 32.
    function automatic word_t rotl(input word_t x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

endpackage

// File: rtl/neokeon_theta.sv
// Combinational Noekeon Theta: linear mixing of the state with the working key.
module neokeon_theta
    import neokeon_pkg::*;
(
    input  logic [127:0] state_in,
    input  logic [127:0] key_in,
    output logic [127:0] state_out
);

    state_t s;
    state_t k;
    word_t  t;

    always_comb begin
        s = split_state(state_in);
        k = split_state(key_in);

        t    = s.a0 ^ s.a2;
        t    = t ^ rotl(t, ROT_THETA) ^ rotr(t, ROT_THETA);
        s.a1 = s.a1 ^ t;
        s.a3 = s.a3 ^ t;

        s.a0 = s.a0 ^ k.a0;
        s.a1 = s.a1 ^ k.a1;
        s.a2 = s.a2 ^ k.a2;
        s.a3 = s.a3 ^ k.a3;

        t    = s.a1 ^ s.a3;
        t    = t ^ rotl(t, ROT_THETA) ^ rotr(t, ROT_THETA);
        s.a0 = s.a0 ^ t;
        s.a2 = s.a2 ^ t;

        state_out = join_state(s);
    end

endmodule

// File: rtl/neokeon_full_round.sv
// One full Noekeon round (c1 add, Theta, c2 add, Pi1, Gamma, Pi2) with registered output.
// Define NEOKEON_ROUND_PIPE_EN to add a register after Theta+c2 (latency 2 instead of 1).
module neokeon_full_round
    import neokeon_pkg::*;
(
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inValid,
    input  logic [127:0] inDataKey,
    input  logic [127:0] inDataState,
    input  logic [31:0]  constant1,
    input  logic [31:0]  constant2,
    output logic [127:0] outDataState,
    output logic         outValid
);

    // Pi1, Gamma and Pi2 applied to the state after the constant2 add.
    function automatic block_t round_tail(input block_t b);
        state_t s;
        word_t  tmp;
        s    = split_state(b);
        s.a1 = rotl(s.a1, PI_ROT_A1);
        s.a2 = rotl(s.a2, PI_ROT_A2);
        s.a3 = rotl(s.a3, PI_ROT_A3);

        s.a1 = s.a1 ^ (~s.a3 & ~s.a2);
        s.a0 = s.a0 ^ (s.a2 & s.a1);
        tmp  = s.a0;
        s.a0 = s.a3;
        s.a3 = tmp;
        s.a2 = s.a2 ^ s.a0 ^ s.a1 ^ s.a3;
        s.a1 = s.a1 ^ (~s.a3 & ~s.a2);
        s.a0 = s.a0 ^ (s.a2 & s.a1);

        s.a1 = rotr(s.a1, PI_ROT_A1);
        s.a2 = rotr(s.a2, PI_ROT_A2);
        s.a3 = rotr(s.a3, PI_ROT_A3);
        return join_state(s);
    endfunction

    block_t pre_theta;
    block_t theta_out;
    block_t post_c2;

    always_comb begin
        pre_theta = inDataState ^ {constant1, 96'h0};
        post_c2   = theta_out ^ {constant2, 96'h0};
    end

    neokeon_theta u_theta (
        .state_in  (pre_theta),
        .key_in    (inDataKey),
        .state_out (theta_out)
    );

    block_t out_state_d;
    block_t out_state_q;
    logic   out_valid_d;
    logic   out_valid_q;

`ifdef NEOKEON_ROUND_PIPE_EN
    block_t mid_state_d;
    block_t mid_state_q;
    logic   mid_valid_d;
    logic   mid_valid_q;

    always_comb begin
        mid_state_d = inValid ? post_c2 : mid_state_q;
        mid_valid_d = inValid;
        out_state_d = mid_valid_q ? round_tail(mid_state_q) : out_state_q;
        out_valid_d = mid_valid_q;
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            mid_state_q <= '0;
            mid_valid_q <= 1'b0;
        end else begin
            mid_state_q <= mid_state_d;
            mid_valid_q <= mid_valid_d;
        end
    end
`else
    always_comb begin
        out_state_d = inValid ? round_tail(post_c2) : out_state_q;
        out_valid_d = inValid;
    end
`endif

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            out_state_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_state_q <= out_state_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign outDataState = out_state_q;
    assign outValid     = out_valid_q;

endmodule

// File: tb/tb_neokeon_full_round.sv
// Directed and streamed checks of neokeon_full_round against a bit-level round model.
module tb_neokeon_full_round;

`ifdef NEOKEON_ROUND_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif
    localparam int NVEC = 6;
    localparam int NSTREAM = 100;

    logic         inClk = 1'b0;
    logic         inRstN = 1'b1;
    logic         inValid = 1'b0;
    logic [127:0] inDataKey = '0;
    logic [127:0] inDataState = '0;
    logic [31:0]  constant1 = '0;
    logic [31:0]  constant2 = '0;
    logic [127:0] outDataState;
    logic         outValid;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [127:0] key;
        logic [127:0] state;
        logic [31:0]  c1;
        logic [31:0]  c2;
        logic [127:0] expected;
    } vec_t;

    vec_t         vecs[NVEC];
    logic [127:0] got_c1_round;
    logic [127:0] got_c2_round;
    logic [127:0] s_key[NSTREAM];
    logic [127:0] s_state[NSTREAM];
    logic [31:0]  s_c1[NSTREAM];
    logic [31:0]  s_c2[NSTREAM];
    logic [127:0] s_exp[NSTREAM];

    neokeon_full_round dut (
        .inClk        (inClk),
        .inRstN       (inRstN),
        .inValid      (inValid),
        .inDataKey    (inDataKey),
        .inDataState  (inDataState),
        .constant1    (constant1),
        .constant2    (constant2),
        .outDataState (outDataState),
        .outValid     (outValid)
    );

    always #5 inClk = ~inClk;

    // Bit-by-bit left rotation; right rotations are expressed as 32-n.
    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) r[(i + n) % 32] = x[i];
        return r;
    endfunction

    function automatic logic [127:0] model_round(input logic [127:0] key, input logic [127:0] st,
                                                  input logic [31:0] c1, input logic [31:0] c2);
        logic [31:0] a[4];
        logic [31:0] k[4];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            a[i] = st[127 - 32*i -: 32];
            k[i] = key[127 - 32*i -: 32];
        end
        a[0] = a[0] ^ c1;
        t = a[0] ^ a[2];
        t = t ^ rol(t, 8) ^ rol(t, 24);
        a[1] = a[1] ^ t;
        a[3] = a[3] ^ t;
        for (int i = 0; i < 4; i++) a[i] = a[i] ^ k[i];
        t = a[1] ^ a[3];
        t = t ^ rol(t, 8) ^ rol(t, 24);
        a[0] = a[0] ^ t;
        a[2] = a[2] ^ t;
        a[0] = a[0] ^ c2;
        a[1] = rol(a[1], 1);
        a[2] = rol(a[2], 5);
        a[3] = rol(a[3], 2);
        a[1] = a[1] ^ (~a[3] & ~a[2]);
        a[0] = a[0] ^ (a[2] & a[1]);
        t = a[0]; a[0] = a[3]; a[3] = t;
        a[2] = a[2] ^ a[0] ^ a[1] ^ a[3];
        a[1] = a[1] ^ (~a[3] & ~a[2]);
        a[0] = a[0] ^ (a[2] & a[1]);
        a[1] = rol(a[1], 31);
        a[2] = rol(a[2], 27);
        a[3] = rol(a[3], 30);
        return {a[0], a[1], a[2], a[3]};
    endfunction

    task automatic check_state(input string name, input logic [127:0] got, input logic [127:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    // Drives one vector for a single cycle, then checks after the fixed latency.
    task automatic apply_vector(input int idx);
        inDataKey   = vecs[idx].key;
        inDataState = vecs[idx].state;
        constant1   = vecs[idx].c1;
        constant2   = vecs[idx].c2;
        inValid     = 1'b1;
        @(posedge inClk); #1;
        inValid = 1'b0;
        repeat (LAT - 1) begin
            @(posedge inClk); #1;
        end
        check_state($sformatf("vec%0d state", idx), outDataState, vecs[idx].expected);
        check_bit($sformatf("vec%0d valid", idx), outValid, 1'b1);
    endtask

    initial begin
        vecs[0] = '{128'h0, 128'h0, 32'h0, 32'h0,
                    128'hFFFFFFFF_FFFFFFFF_FFFFFFFF_00000000};
        vecs[1] = '{128'h0, 128'h0, 32'h80, 32'h0,
                    128'hFFFEFE7E_FFFEFEFE_F7FFF7F3_00000020};
        vecs[2] = '{{128{1'b1}}, 128'h0, 32'h0, 32'h0,
                    128'h00000000_FFFFFFFF_FFFFFFFF_00000000};
        vecs[3] = '{128'h0, 128'h0, 32'h0, 32'h80,
                    128'hFFFFFF7F_FFFFFFFF_FFFFFFFB_00000020};
        vecs[4] = '{128'hb1656851699e29fa24b70148503d2dfc, 128'h2a78421b87c7d0924f26113f1d1349b2,
                    32'h80, 32'h0, 128'h0};
        vecs[5] = '{128'hb1656851699e29fa24b70148503d2dfc, 128'h2a78421b87c7d0924f26113f1d1349b2,
                    32'h0, 32'h80, 128'h0};
        for (int i = 4; i < NVEC; i++)
            vecs[i].expected = model_round(vecs[i].key, vecs[i].state, vecs[i].c1, vecs[i].c2);

        // Reset held with live inputs: outputs must stay cleared.
        #1;
        inRstN      = 1'b0;
        inValid     = 1'b1;
        inDataKey   = 128'h0123456789abcdef0123456789abcdef;
        inDataState = 128'hfedcba9876543210fedcba9876543210;
        constant1   = 32'h80;
        #1;
        check_state("reset state async", outDataState, 128'h0);
        check_bit("reset valid async", outValid, 1'b0);
        repeat (3) @(posedge inClk);
        #1;
        check_state("reset state held", outDataState, 128'h0);
        check_bit("reset valid held", outValid, 1'b0);
        inValid = 1'b0;
        inRstN  = 1'b1;
        @(posedge inClk); #1;

        for (int i = 0; i < NVEC; i++) begin
            apply_vector(i);
            if (i == 4) got_c1_round = outDataState;
            if (i == 5) got_c2_round = outDataState;
        end
        checks++;
        if (got_c1_round === got_c2_round) begin
            failures++;
            $display("FAIL c1_vs_c2 differ: got %h want value != %h", got_c2_round, got_c1_round);
        end

        // One idle cycle after the last vector: output holds, valid drops.
        @(posedge inClk); #1;
        check_state("idle hold state", outDataState, vecs[NVEC-1].expected);
        check_bit("idle valid", outValid, 1'b0);

        for (int i = 0; i < NSTREAM; i++) begin
            s_key[i]   = {$urandom, $urandom, $urandom, $urandom};
            s_state[i] = {$urandom, $urandom, $urandom, $urandom};
            s_c1[i]    = $urandom;
            s_c2[i]    = $urandom;
            s_exp[i]   = model_round(s_key[i], s_state[i], s_c1[i], s_c2[i]);
        end
        for (int c = 0; c < NSTREAM + LAT - 1; c++) begin
            if (c < NSTREAM) begin
                inDataKey   = s_key[c];
                inDataState = s_state[c];
                constant1   = s_c1[c];
                constant2   = s_c2[c];
                inValid     = 1'b1;
            end else begin
                inValid = 1'b0;
            end
            @(posedge inClk); #1;
            if (c - LAT + 1 >= 0) begin
                check_state($sformatf("stream%0d state", c - LAT + 1), outDataState, s_exp[c - LAT + 1]);
                check_bit($sformatf("stream%0d valid", c - LAT + 1), outValid, 1'b1);
            end
        end
        inValid = 1'b0;
        @(posedge inClk); #1;
        check_state("stream hold state", outDataState, s_exp[NSTREAM-1]);
        check_bit("stream hold valid", outValid, 1'b0);

        // Reset asserted between edges while a stream is flowing.
        for (int c = 0; c < 3; c++) begin
            inDataKey   = s_key[c];
            inDataState = s_state[c];
            constant1   = s_c1[c];
            constant2   = s_c2[c];
            inValid     = 1'b1;
            @(posedge inClk); #1;
        end
        check_bit("midstream valid before reset", outValid, 1'b1);
        #2;
        inRstN = 1'b0;
        #1;
        check_state("midstream reset state", outDataState, 128'h0);
        check_bit("midstream reset valid", outValid, 1'b0);
        @(posedge inClk); #1;
        check_state("midstream reset held", outDataState, 128'h0);
        check_bit("midstream reset valid held", outValid, 1'b0);
        inValid = 1'b0;
        inRstN  = 1'b1;
        @(posedge inClk); #1;
        check_bit("post reset no stale valid", outValid, 1'b0);
        apply_vector(1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
